// File: rtl/client_sink_if.sv
// Ejection-port bundle feeding the client sink: one beat per cycle, no backpressure.
interface client_sink_if #(
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int D_W = 512
);
  logic           o_v;
  logic [X_W-1:0] o_x;
  logic [Y_W-1:0] o_y;
  logic [D_W-1:0] o_data;

  modport master (output o_v, output o_x, output o_y, output o_data);
  modport slave  (input  o_v, input  o_x, input  o_y, input  o_data);
endinterface

// File: rtl/client_sink.sv
// Client sink: counts ejected beats addressed to this node, checks per-source
// sequence continuity, and flags misrouted beats and beats arriving after done.
// Two-stage pipeline: stage 1 registers the beat, stage 2 evaluates it.
module client_sink #(
  parameter int X_W       = 2,
  parameter int Y_W       = 2,
  parameter int X         = 2,
  parameter int Y         = 2,
  parameter int D_W       = 512,
  parameter int N_PACKETS = 128
) (
  input  logic               clk,
  input  logic               rst,
  client_sink_if.slave       ej,
  output logic [31:0]        rx_count,
  output logic               err_dest,
  output logic               err_seq,
  output logic               err_extra,
  output logic [X_W+Y_W-1:0] err_src,
  output logic               done
);
  localparam int             SRC_W = X_W + Y_W;
  localparam int             NSRC  = 1 << SRC_W;
  localparam int             PAY_W = 16 + SRC_W;
  localparam logic [X_W-1:0] OWN_X = X_W'(X);
  localparam logic [Y_W-1:0] OWN_Y = Y_W'(Y);
  localparam logic [31:0]    LAST  = 32'(N_PACKETS - 1);

  typedef struct packed {
    logic             v;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [SRC_W-1:0] src;
    logic [15:0]      seq;
  } beat_t;

  typedef enum logic {RUN, DONE} state_t;

  beat_t       s1;
  state_t      state;
  logic [15:0] exp_seq [NSRC];

  // Payload bits above the sequence/source header are dropped on purpose.
  logic unused_data;
  assign unused_data = ^ej.o_data;

  // Stage 1: capture the beat header every cycle; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.v   <= ej.o_v;
      s1.x   <= ej.o_x;
      s1.y   <= ej.o_y;
      s1.src <= ej.o_data[PAY_W-1:16];
      s1.seq <= ej.o_data[15:0];
    end
  end

  // Stage 2: destination check, counting, done FSM and per-source sequence tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      rx_count  <= '0;
      err_dest  <= 1'b0;
      err_seq   <= 1'b0;
      err_extra <= 1'b0;
      err_src   <= '0;
      done      <= 1'b0;
      for (int i = 0; i < NSRC; i++) exp_seq[i] <= '0;
    end else if (s1.v) begin
      if (s1.x != OWN_X || s1.y != OWN_Y) begin
        // Misrouted beat: flag only, leave count and sequence state untouched.
        err_dest <= 1'b1;
      end else begin
        if (rx_count != '1) rx_count <= rx_count + 32'd1;
        case (state)
          RUN: begin
            if (rx_count == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: err_extra <= 1'b1;
          default: state <= RUN;
        endcase
        // A gap or repeat is reported, then tracking resyncs to the received number.
        if (s1.seq != exp_seq[s1.src]) begin
          err_seq <= 1'b1;
          err_src <= s1.src;
        end
        exp_seq[s1.src] <= s1.seq + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_client_sink.sv
// Self-checking bench for client_sink: directed table, multi-cycle corner
// sequences, and randomized beats checked against a behavioural model.
module tb_client_sink;
  localparam int NP = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rx_count;
  logic        err_dest, err_seq, err_extra, done;
  logic [3:0]  err_src;

  client_sink_if #(.X_W(2), .Y_W(2), .D_W(512)) ej ();

  client_sink #(.X_W(2), .Y_W(2), .X(2), .Y(2), .D_W(512), .N_PACKETS(NP)) dut (
    .clk(clk), .rst(rst), .ej(ej),
    .rx_count(rx_count), .err_dest(err_dest), .err_seq(err_seq),
    .err_extra(err_extra), .err_src(err_src), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: counters and flags updated straight from the rules.
  logic [31:0] m_cnt;
  logic        m_ed, m_es, m_ex, m_done;
  logic [3:0]  m_src;
  logic [15:0] m_exp [16];
  logic [39:0] snap_d1, snap_d2;

  typedef struct {
    logic        v;
    logic [1:0]  x, y;
    logic [3:0]  src;
    logic [15:0] seq;
    logic [31:0] cnt;
    logic        ed, es;
    logic [3:0]  esrc;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [39:0] dut_vec();
    return {rx_count, err_dest, err_seq, err_extra, err_src, done};
  endfunction

  function automatic logic [39:0] mvec();
    return {m_cnt, m_ed, m_es, m_ex, m_src, m_done};
  endfunction

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic apply_reset();
    ej.o_v = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    m_cnt = '0; m_ed = 0; m_es = 0; m_ex = 0; m_done = 0; m_src = '0;
    for (int i = 0; i < 16; i++) m_exp[i] = '0;
    snap_d1 = '0;
    snap_d2 = '0;
  endtask

  // One cycle: check the output due now (beat from two cycles ago), drive a beat,
  // advance the model, then move just past the next rising edge.
  task automatic step(input logic v, input logic [1:0] x, input logic [1:0] y,
                      input logic [3:0] src, input logic [15:0] seq);
    chk("model", dut_vec(), snap_d2);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ej.o_data[i*32 +: 32] = $urandom;
    ej.o_data[15:0]  = seq;
    ej.o_data[19:16] = src;
    ej.o_v = v;
    ej.o_x = x;
    ej.o_y = y;
    if (v) begin
      if (x != 2'd2 || y != 2'd2) m_ed = 1'b1;
      else begin
        if (m_done) m_ex = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!m_done && m_cnt == NP) m_done = 1'b1;
        if (seq != m_exp[src]) begin
          m_es  = 1'b1;
          m_src = src;
        end
        m_exp[src] = seq + 16'd1;
      end
    end
    snap_d2 = snap_d1;
    snap_d1 = mvec();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 2'd0, 4'd0, 16'd0);
  endtask

  initial begin
    // v, x, y, src, seq -> cnt, err_dest, err_seq, err_src (observed two cycles later)
    tbl[0] = '{1, 2, 2, 2, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 2, 2, 2, 1, 2, 0, 0, 0};
    tbl[2] = '{1, 2, 2, 2, 3, 3, 0, 1, 2};
    tbl[3] = '{1, 2, 2, 2, 4, 4, 0, 1, 2};
    tbl[4] = '{1, 3, 2, 2, 5, 4, 1, 1, 2};
    tbl[5] = '{1, 2, 2, 2, 5, 5, 1, 1, 2};
    tbl[6] = '{0, 2, 2, 1, 9, 5, 1, 1, 2};
    tbl[7] = '{1, 2, 2, 1, 7, 6, 1, 1, 1};

    ej.o_v = 1'b0; ej.o_x = '0; ej.o_y = '0; ej.o_data = '0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    chk("reset", dut_vec(), 40'd0);

    // Directed table: sequence gap, resync, misroute, idle beat, second source error.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].src, tbl[i].seq);
      idle();
      chk("tbl", dut_vec(), {tbl[i].cnt, tbl[i].ed, tbl[i].es, 1'b0, tbl[i].esrc, 1'b0});
    end

    // 128 back-to-back beats from source 1; done lands exactly two cycles after the last.
    apply_reset();
    for (int i = 0; i < NP; i++) step(1'b1, 2'd2, 2'd2, 4'd1, 16'(i));
    chk("done_lat1", {39'd0, done}, 40'd0);
    idle();
    chk("cnt128", {8'd0, rx_count}, 40'd128);
    chk("done_lat2", {39'd0, done}, 40'd1);
    chk("errs_clean", {37'd0, err_dest, err_seq, err_extra}, 40'd0);
    step(1'b1, 2'd2, 2'd2, 4'd1, 16'(NP));
    idle();
    chk("extra", {rx_count, err_extra, done, 6'd0}, {32'(NP + 1), 1'b1, 1'b1, 6'd0});

    // Reset one cycle after presenting a beat: the beat is dropped.
    step(1'b1, 2'd2, 2'd2, 4'd1, 16'(NP + 1));
    apply_reset();
    chk("rst_mid", dut_vec(), 40'd0);
    idle();
    idle();
    chk("rst_discard", dut_vec(), 40'd0);

    // Randomized traffic against the model.
    apply_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [3:0]  s;
      logic [15:0] q;
      logic [1:0]  dx;
      s  = 4'($urandom_range(0, 15));
      q  = ($urandom_range(0, 9) < 8) ? m_exp[s] : 16'($urandom);
      dx = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'd2;
      step(1'($urandom_range(0, 3) != 0), dx, 2'd2, s, q);
    end
    idle();
    idle();

    // Sequence wrap: source 3 runs 0..0xFFFF then 0x0000 with no sequence error.
    apply_reset();
    for (int i = 0; i < 65536; i++) step(1'b1, 2'd2, 2'd2, 4'd3, 16'(i));
    step(1'b1, 2'd2, 2'd2, 4'd3, 16'd0);
    idle();
    idle();
    chk("wrap_seq", {39'd0, err_seq}, 40'd0);
    chk("wrap_cnt", {8'd0, rx_count}, 40'd65537);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
